// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, derived sizing and output formatting for the FIR engine
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Width of the formatting datapath; must exceed any accumulator width in use.
  localparam int MATH_W = 64;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAPS   = 16;
  localparam int DEF_LANES  = 4;

  function automatic int calc_passes(input int taps, input int lanes);
    return taps / lanes;
  endfunction

  function automatic int calc_acc_w(input int data_w, input int taps);
    return 2 * data_w + $clog2(taps);
  endfunction

  localparam int DEF_P     = calc_passes(DEF_TAPS, DEF_LANES);
  localparam int DEF_ACC_W = calc_acc_w(DEF_DATA_W, DEF_TAPS);

  typedef struct packed {
    logic [MATH_W-1:0] data;
    logic              sat;
  } rs_t;

  // acc must arrive sign- or zero-extended to MATH_W to match sgn.
  function automatic rs_t round_sat(input logic [MATH_W-1:0] acc, input int shift,
                                    input int dw, input logic sgn);
    logic signed [MATH_W-1:0] v;
    logic signed [MATH_W-1:0] one;
    logic signed [MATH_W-1:0] hi;
    logic signed [MATH_W-1:0] lo;
    rs_t r;
    one = MATH_W'(1);
    v   = $signed(acc);
    if (shift > 0) begin
      v = v + (one <<< (shift - 1));
    end
    v = v >>> shift;
    if (sgn) begin
      hi = (one <<< (dw - 1)) - one;
      lo = -(one <<< (dw - 1));
    end else begin
      hi = (one <<< dw) - one;
      lo = '0;
    end
    r.sat  = 1'b0;
    r.data = v;
    if (v > hi) begin
      r.data = hi;
      r.sat  = 1'b1;
    end else if (v < lo) begin
      r.data = lo;
      r.sat  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tap_shift_reg.sv
// rtl/tap_shift_reg.sv - serially loaded tap register, entry 0 takes the newest word
module tap_shift_reg #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q [DEPTH]
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < DEPTH; k++) begin
        q[k] <= '0;
      end
    end else if (we) begin
      q[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        q[k] <= q[k-1];
      end
    end
  end

endmodule

// File: rtl/fir_mac_param.sv
// rtl/fir_mac_param.sv - time-multiplexed FIR: LANES multipliers over TAPS/LANES passes
module fir_mac_param
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TAPS      = 16,
  parameter int LANES     = 4,
  parameter bit SIGNED    = 1'b1,
  parameter int OUT_SHIFT = 0,
  parameter int ACC_W     = calc_acc_w(DATA_W, TAPS)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              coef_we,
  input  logic [DATA_W-1:0] coef_in,
  input  logic              samp_we,
  input  logic [DATA_W-1:0] samp_in,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sat
);

  localparam int P      = calc_passes(TAPS, LANES);
  localparam int G_W    = (P > 1) ? $clog2(P) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W - PROD_W;

  logic [DATA_W-1:0] coef [TAPS];
  logic [DATA_W-1:0] samp [TAPS];

  state_t          state;
  state_t          state_nx;
  logic [G_W-1:0]  grp;
  logic            drain_cnt;
  logic            accept;
  logic            issue;
  logic            last_grp;

  logic [DATA_W-1:0] lane_d [LANES];
  logic [DATA_W-1:0] lane_w [LANES];

  logic [PROD_W-1:0] prod [LANES];
  logic              s1_valid, s1_first, s1_last;
  logic [ACC_W-1:0]  sum;
  logic              s2_valid, s2_first, s2_last;
  logic [ACC_W-1:0]  acc;
  logic              acc_done;

  rs_t  fmt;
  logic unused_fmt_hi;

  // Writes landing while a convolution is in flight are dropped, never deferred.
  tap_shift_reg #(.DEPTH(TAPS), .WIDTH(DATA_W)) u_coef (
    .clk  (clk),
    .rstb (rstb),
    .we   (coef_we & ~busy),
    .din  (coef_in),
    .q    (coef)
  );

  tap_shift_reg #(.DEPTH(TAPS), .WIDTH(DATA_W)) u_samp (
    .clk  (clk),
    .rstb (rstb),
    .we   (samp_we & ~busy),
    .din  (samp_in),
    .q    (samp)
  );

  assign accept   = start && (state == ST_IDLE);
  assign last_grp = (grp == G_W'(P - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (start)     state_nx = ST_RUN;
      ST_RUN:   if (last_grp)  state_nx = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_nx = ST_IDLE;
      default:                 state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    issue = (state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      grp       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (accept) begin
        grp <= '0;
      end else if (issue) begin
        grp <= grp + 1'b1;
      end
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_d[i] = '0;
      lane_w[i] = '0;
      for (int gg = 0; gg < P; gg++) begin
        if (grp == G_W'(gg)) begin
          lane_d[i] = samp[gg*LANES+i];
          lane_w[i] = coef[gg*LANES+i];
        end
      end
    end
  end

  // Operands are pre-extended so the low PROD_W bits of the product are exact in either mode.
  function automatic logic [PROD_W-1:0] mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] xa;
    logic [PROD_W-1:0] xb;
    xa = {{DATA_W{a[DATA_W-1] & SIGNED}}, a};
    xb = {{DATA_W{b[DATA_W-1] & SIGNED}}, b};
    return xa * xb;
  endfunction

  function automatic logic [ACC_W-1:0] tree_sum(input logic [PROD_W-1:0] p [LANES]);
    logic [ACC_W-1:0] node [2*LANES-1];
    for (int i = 0; i < LANES; i++) begin
      node[LANES-1+i] = {{EXT_W{p[i][PROD_W-1] & SIGNED}}, p[i]};
    end
    for (int n = LANES - 2; n >= 0; n--) begin
      node[n] = node[2*n+1] + node[2*n+2];
    end
    return node[0];
  endfunction

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= '0;
      end
    end else begin
      s1_valid <= issue;
      s1_first <= issue && (grp == '0);
      s1_last  <= issue && last_grp;
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= mul(lane_d[i], lane_w[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      sum      <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      sum      <= tree_sum(prod);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      if (s2_valid) begin
        acc <= s2_first ? sum : acc + sum;
      end
      acc_done <= s2_valid && s2_last;
    end
  end

  assign fmt = round_sat({{(MATH_W-ACC_W){acc[ACC_W-1] & SIGNED}}, acc}, OUT_SHIFT, DATA_W, SIGNED);
  // Above DATA_W the clipped value is only sign extension.
  assign unused_fmt_hi = ^fmt.data[MATH_W-1:DATA_W];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= acc_done;
      if (acc_done) begin
        out_data <= fmt.data[DATA_W-1:0];
        sat      <= fmt.sat;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// tb/tb_fir_mac_param.sv - directed checks of fir_mac_param across several parameter sets
module tb_fir_mac_param;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        coef_we = 1'b0;
  logic        samp_we = 1'b0;
  logic        start = 1'b0;
  logic [15:0] coef_in = 16'h0;
  logic [15:0] samp_in = 16'h0;

  logic busy_def, ov_def, sat_def;
  logic busy_sh4, ov_sh4, sat_sh4;
  logic busy_uns, ov_uns, sat_uns;
  logic busy_t8, ov_t8, sat_t8;
  logic busy_t4, ov_t4, sat_t4;
  logic [15:0] od_def, od_sh4, od_uns, od_t8, od_t4;

  int checks = 0;
  int errors = 0;
  logic [15:0] hist_def, hist_t8, hist_t4, busy_hist;

  int wv [8] = '{2, 4, -3, 1, 6, -5, 9, 10};
  int dv [8] = '{3, -1, 5, 100, -7, 2, 0, -300};

  always #5 clk = ~clk;

  fir_mac_param u_def (
    .clk(clk), .rstb(rstb), .coef_we(coef_we), .coef_in(coef_in), .samp_we(samp_we),
    .samp_in(samp_in), .start(start), .busy(busy_def), .out_valid(ov_def),
    .out_data(od_def), .sat(sat_def)
  );

  fir_mac_param #(.OUT_SHIFT(4)) u_sh4 (
    .clk(clk), .rstb(rstb), .coef_we(coef_we), .coef_in(coef_in), .samp_we(samp_we),
    .samp_in(samp_in), .start(start), .busy(busy_sh4), .out_valid(ov_sh4),
    .out_data(od_sh4), .sat(sat_sh4)
  );

  fir_mac_param #(.SIGNED(1'b0)) u_uns (
    .clk(clk), .rstb(rstb), .coef_we(coef_we), .coef_in(coef_in), .samp_we(samp_we),
    .samp_in(samp_in), .start(start), .busy(busy_uns), .out_valid(ov_uns),
    .out_data(od_uns), .sat(sat_uns)
  );

  fir_mac_param #(.TAPS(8), .LANES(2)) u_t8 (
    .clk(clk), .rstb(rstb), .coef_we(coef_we), .coef_in(coef_in), .samp_we(samp_we),
    .samp_in(samp_in), .start(start), .busy(busy_t8), .out_valid(ov_t8),
    .out_data(od_t8), .sat(sat_t8)
  );

  fir_mac_param #(.TAPS(4), .LANES(4)) u_t4 (
    .clk(clk), .rstb(rstb), .coef_we(coef_we), .coef_in(coef_in), .samp_we(samp_we),
    .samp_in(samp_in), .start(start), .busy(busy_t4), .out_valid(ov_t4),
    .out_data(od_t4), .sat(sat_t4)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c, input logic [15:0] s);
    coef_we = 1'b1;
    samp_we = 1'b1;
    coef_in = c;
    samp_in = s;
    @(posedge clk); #1;
    coef_we = 1'b0;
    samp_we = 1'b0;
  endtask

  task automatic fill(input logic [15:0] c, input logic [15:0] s);
    for (int k = 0; k < 16; k++) push(c, s);
  endtask

  // Leaves d[k] = k+1 and w[k] = w in every instance.
  task automatic fill_ramp(input logic [15:0] w);
    for (int k = 15; k >= 0; k--) push(w, 16'(k + 1));
  endtask

  // Edge 0 accepts start; hist bit e records out_valid just after edge e.
  task automatic run(input int n, input int restart_at, input int wr_at);
    start     = 1'b1;
    hist_def  = 16'h0;
    hist_t8   = 16'h0;
    hist_t4   = 16'h0;
    busy_hist = 16'h0;
    for (int e = 0; e < n; e++) begin
      @(posedge clk); #1;
      start   = 1'b0;
      samp_we = 1'b0;
      hist_def[e]  = ov_def;
      hist_t8[e]   = ov_t8;
      hist_t4[e]   = ov_t4;
      busy_hist[e] = busy_def;
      if (e + 1 == restart_at || e + 1 == wr_at) start = 1'b1;
      if (e + 1 == wr_at) begin
        samp_we = 1'b1;
        samp_in = 16'h0100;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy_def), 16'h0);
    chk("rst_out_valid", 16'(ov_def), 16'h0);
    chk("rst_out_data", od_def, 16'h0);
    chk("rst_sat", 16'(sat_def), 16'h0);
    rstb = 1'b1;
    @(posedge clk); #1;

    fill_ramp(16'd1);
    run(10, -1, -1);
    chk("t1_valid_timing", hist_def, 16'h0080);
    chk("t1_busy_timing", busy_hist, 16'h003F);
    chk("t1_def_data", od_def, 16'd136);
    chk("t1_def_sat", 16'(sat_def), 16'h0);
    chk("t1_sh4_data", od_sh4, 16'd9);
    chk("t1_uns_data", od_uns, 16'd136);
    chk("t1_t8_data", od_t8, 16'd36);
    chk("t1_t8_timing", hist_t8, 16'h0080);
    chk("t1_t4_data", od_t4, 16'd10);
    chk("t1_t4_timing", hist_t4, 16'h0010);

    fill(16'd3, 16'hFFFE);
    run(10, -1, -1);
    chk("t2_def_neg96", od_def, 16'hFFA0);
    chk("t2_def_sat", 16'(sat_def), 16'h0);
    chk("t2_sh4_neg6", od_sh4, 16'hFFFA);
    chk("t2_uns_clip", od_uns, 16'hFFFF);
    chk("t2_uns_sat", 16'(sat_uns), 16'h1);
    chk("t2_t8_neg48", od_t8, 16'hFFD0);
    chk("t2_t4_neg24", od_t4, 16'hFFE8);

    fill(16'h7FFF, 16'h7FFF);
    run(10, -1, -1);
    chk("t3_def_posclip", od_def, 16'h7FFF);
    chk("t3_def_sat", 16'(sat_def), 16'h1);
    chk("t3_sh4_posclip", od_sh4, 16'h7FFF);
    chk("t3_uns_clip", od_uns, 16'hFFFF);
    fill(16'hFFFF, 16'hFFFF);
    run(10, -1, -1);
    chk("t3_def_ones", od_def, 16'h0010);
    chk("t3_def_ones_sat", 16'(sat_def), 16'h0);
    chk("t3_sh4_ones", od_sh4, 16'h0001);
    chk("t3_uns_ones", od_uns, 16'hFFFF);
    chk("t3_uns_ones_sat", 16'(sat_uns), 16'h1);
    fill(16'h7FFF, 16'h8000);
    run(10, -1, -1);
    chk("t3_def_negclip", od_def, 16'h8000);
    chk("t3_def_negsat", 16'(sat_def), 16'h1);

    fill_ramp(16'd1);
    run(14, -1, 2);
    chk("t4_single_pulse", hist_def, 16'h0080);
    chk("t4_data", od_def, 16'd136);
    run(10, -1, -1);
    chk("t4_regs_kept_pulse", hist_def, 16'h0080);
    chk("t4_regs_kept_data", od_def, 16'd136);
    run(16, 7, -1);
    chk("t4_back_to_back", hist_def, 16'h4080);
    chk("t4_b2b_data", od_def, 16'd136);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rstb = 1'b0;
    #1;
    chk("t5_busy", 16'(busy_def), 16'h0);
    chk("t5_out_valid", 16'(ov_def), 16'h0);
    chk("t5_out_data", od_def, 16'h0);
    chk("t5_sat", 16'(sat_def), 16'h0);
    chk("t5_t4_out_data", od_t4, 16'h0);
    @(posedge clk); #1;
    rstb = 1'b1;
    hist_def = 16'h0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      hist_def[e] = ov_def;
    end
    chk("t5_no_pulse", hist_def, 16'h0);
    fill_ramp(16'd2);
    run(10, -1, -1);
    chk("t5_rerun_timing", hist_def, 16'h0080);
    chk("t5_rerun_def", od_def, 16'h0110);
    chk("t5_rerun_sh4", od_sh4, 16'h0011);
    chk("t5_rerun_t8", od_t8, 16'h0048);
    chk("t5_rerun_t4", od_t4, 16'h0014);

    for (int k = 7; k >= 0; k--) push(16'(wv[k]), 16'(dv[k]));
    run(10, -1, -1);
    chk("t6_t8_data", od_t8, 16'hF46B);
    chk("t6_t8_sat", 16'(sat_t8), 16'h0);
    chk("t6_t8_timing", hist_t8, 16'h0080);
    chk("t6_t4_data", od_t4, 16'h0057);
    chk("t6_t4_timing", hist_t4, 16'h0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
